// File: rtl/i2c_target_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_reg_bridge
// Description : I2C target that turns byte transfers into a parallel register
//               port. First data byte after a write address loads the register
//               pointer; later bytes are writes, or reads after a repeated
//               start. Pointer auto-increments and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_reg_bridge #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 3,
    parameter int         ADDR_WIDTH  = 8
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [7:0]            reg_wdata_o,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    input  logic [7:0]            reg_rdata_i,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through the conditioning path.
    logic [1:0] pad;
    logic [1:0] filt;
    logic [1:0] prev;

    assign pad = {scl_i, sda_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic             s1;
            logic             s2;
            logic             f;
            logic [CNT_W-1:0] cnt;

            // Two-flop synchronizer followed by a run-length filter: the output
            // only follows the input after FILTER_LEN consecutive differing samples.
            always_ff @(posedge wb_clk or posedge wb_rst) begin
                if (wb_rst) begin
                    s1  <= 1'b1;
                    s2  <= 1'b1;
                    f   <= 1'b1;
                    cnt <= '0;
                end else begin
                    s1 <= pad[gi];
                    s2 <= s1;
                    if (s2 == f) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        f   <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign filt[gi] = f;
        end
    endgenerate

    // Previous filtered sample for edge and condition detection.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) prev <= 2'b11;
        else        prev <= filt;
    end

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_p     = prev[1];
    assign sda_p     = prev[0];
    assign scl_rise  = ~scl_p & scl_f;
    assign scl_fall  = scl_p & ~scl_f;
    assign start_det = scl_p & scl_f & sda_p & ~sda_f;
    assign stop_det  = scl_p & scl_f & ~sda_p & sda_f;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            shreg;
    logic [2:0]            bit_cnt;
    logic                  sda_oe;
    logic                  we;
    logic                  re;
    logic                  re_d;
    logic [7:0]            wdata;
    logic                  busy;
    logic                  rw;
    logic                  ack_on;
    logic                  fall_d;
    logic [7:0]            rx_byte;

    assign rx_byte = {shreg[6:0], sda_f};

    // Protocol engine: byte reception, ACK/data driving on SDA, register strobes.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            re_d    <= 1'b0;
            wdata   <= '0;
            busy    <= 1'b0;
            rw      <= 1'b0;
            ack_on  <= 1'b0;
            fall_d  <= 1'b0;
        end else begin
            we     <= 1'b0;
            re     <= 1'b0;
            re_d   <= re;
            fall_d <= scl_fall;
            // Pointer advances on the cycle following a write strobe.
            if (we) ptr <= ptr + ADDR_WIDTH'(1);
            // Read data is captured one cycle after the read request.
            if (re_d) shreg <= reg_rdata_i;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state <= ADDR_ACK;
                                    busy  <= 1'b1;
                                    rw    <= sda_f;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        // Read address: fetch the first byte on the 8th SCL fall.
                        if (state == ADDR_ACK && rw && scl_fall && !ack_on) re <= 1'b1;
                        if (fall_d) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    sda_oe <= ~shreg[7];
                                    shreg  <= {shreg[6:0], 1'b0};
                                    state  <= RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr   <= ADDR_WIDTH'(rx_byte);
                                state <= PTR_ACK;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wdata <= rx_byte;
                                we    <= 1'b1;
                                state <= WDATA_ACK;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                        if (fall_d) begin
                            // bit_cnt wraps to 0 once all eight bits have been clocked.
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                ack_on <= 1'b0;
                                state  <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~shreg[7];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + ADDR_WIDTH'(1);
                            if (!sda_f) begin
                                re     <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        if (fall_d && ack_on) begin
                            sda_oe  <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= '0;
                            ack_on  <= 1'b0;
                            state   <= RDATA;
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe_o    = sda_oe;
    assign reg_addr_o  = ptr;
    assign reg_wdata_o = wdata;
    assign reg_we_o    = we;
    assign reg_re_o    = re;
    assign busy_o      = busy;

endmodule
`default_nettype wire
